// File: rtl/reg_file_sb.sv
// Multi-port register file with a pending-write (busy) scoreboard for the ID stage; r0 reads as zero and is never busy.
// Reads and issueStall are combinational (0 cycles); write, issue and flush update state at the next rising clk edge.
// No backpressure on writes; an issue to a register already pending is refused through issueStall (WAW).
//
// Optional feature macro: REGFILE_BYPASS_EN -- forward same-cycle writeData to matching read ports and clear their rdBusy.
//
// Ports:
//   clk, rstN                     clock, asynchronous active-low reset
//   rdAdr / rdData / rdBusy       READ_PORTS packed read ports (port i at [i*ADDR_W +: ADDR_W] / [i*WIDTH +: WIDTH] / [i])
//   regWrite, writeAdr, writeData synchronous write port; completing a write clears the register's busy bit
//   issueValid, issueAdr          mark a destination register as pending; issueStall refuses it on a WAW hazard
//   flush                         clear all busy bits (squash)
//   busyCount                     registered number of busy registers
module reg_file_sb #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = 5,
  parameter int READ_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic [READ_PORTS*ADDR_W-1:0] rdAdr,
  output logic [READ_PORTS*WIDTH-1:0]  rdData,
  output logic [READ_PORTS-1:0]        rdBusy,
  input  logic                         regWrite,
  input  logic [ADDR_W-1:0]            writeAdr,
  input  logic [WIDTH-1:0]             writeData,
  input  logic                         issueValid,
  input  logic [ADDR_W-1:0]            issueAdr,
  output logic                         issueStall,
  input  logic                         flush,
  output logic [ADDR_W:0]              busyCount
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busyNext;
  logic [ADDR_W:0]  countNext;
  logic             wrEn;
  logic             issueAcc;

  assign wrEn = regWrite && (writeAdr != '0);

  // A write landing this edge to the same register satisfies the old
  // producer, so the new issue may proceed (it becomes the new producer).
  assign issueStall = issueValid && (issueAdr != '0) && busy[issueAdr] &&
                      !(regWrite && (writeAdr == issueAdr));

  assign issueAcc = issueValid && !issueStall && (issueAdr != '0) && !flush;

  // Next busy vector: the completing write clears first, so an accepted
  // issue to the same register re-sets it; flush overrides both.
  always_comb begin
    busyNext = busy;
    if (wrEn) busyNext[writeAdr] = 1'b0;
    if (issueAcc) busyNext[issueAdr] = 1'b1;
    if (flush) busyNext = '0;
    busyNext[0] = 1'b0;
  end

  // busyCount is registered from busyNext so it always tracks busy exactly.
  always_comb begin
    countNext = '0;
    for (int i = 0; i < DEPTH; i++) begin
      countNext = countNext + {{ADDR_W{1'b0}}, busyNext[i]};
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy      <= '0;
      busyCount <= '0;
    end else begin
      if (wrEn) mem[writeAdr] <= writeData;
      busy      <= busyNext;
      busyCount <= countNext;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] adr;
    adr    = '0;
    rdData = '0;
    rdBusy = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      adr = rdAdr[i*ADDR_W +: ADDR_W];
      if (adr == '0) begin
        rdData[i*WIDTH +: WIDTH] = '0;
        rdBusy[i]                = 1'b0;
      end else if (BYPASS && regWrite && (writeAdr == adr)) begin
        rdData[i*WIDTH +: WIDTH] = writeData;
        rdBusy[i]                = 1'b0;
      end else begin
        rdData[i*WIDTH +: WIDTH] = mem[adr];
        rdBusy[i]                = busy[adr];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  logic        clk;
  logic        rstN;
  logic [9:0]  rdAdr;
  logic [63:0] rdData;
  logic [1:0]  rdBusy;
  logic        regWrite;
  logic [4:0]  writeAdr;
  logic [31:0] writeData;
  logic        issueValid;
  logic [4:0]  issueAdr;
  logic        issueStall;
  logic        flush;
  logic [5:0]  busyCount;

  // Small configuration: WIDTH=16, DEPTH=8, READ_PORTS=4
  logic [11:0] sRdAdr;
  logic [63:0] sRdData;
  logic [3:0]  sRdBusy;
  logic        sRegWrite;
  logic [2:0]  sWriteAdr;
  logic [15:0] sWriteData;
  logic        sIssueValid;
  logic [2:0]  sIssueAdr;
  logic        sIssueStall;
  logic        sFlush;
  logic [3:0]  sBusyCount;

  int checks;
  int failures;

  reg_file_sb #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .READ_PORTS(2)) dut (
    .clk(clk), .rstN(rstN), .rdAdr(rdAdr), .rdData(rdData), .rdBusy(rdBusy),
    .regWrite(regWrite), .writeAdr(writeAdr), .writeData(writeData),
    .issueValid(issueValid), .issueAdr(issueAdr), .issueStall(issueStall),
    .flush(flush), .busyCount(busyCount)
  );

  reg_file_sb #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .READ_PORTS(4)) dutSmall (
    .clk(clk), .rstN(rstN), .rdAdr(sRdAdr), .rdData(sRdData), .rdBusy(sRdBusy),
    .regWrite(sRegWrite), .writeAdr(sWriteAdr), .writeData(sWriteData),
    .issueValid(sIssueValid), .issueAdr(sIssueAdr), .issueStall(sIssueStall),
    .flush(sFlush), .busyCount(sBusyCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wr, wa, wd, iv, ia, fl, ra0, ra1;
    logic [31:0] ed0, ed1, eb0, eb1, es, ec;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    regWrite = 1'b0; writeAdr = '0; writeData = '0;
    issueValid = 1'b0; issueAdr = '0; flush = 1'b0;
    sRegWrite = 1'b0; sWriteAdr = '0; sWriteData = '0;
    sIssueValid = 1'b0; sIssueAdr = '0; sFlush = 1'b0;
  endtask

  task automatic applyVec(input vec_t v, input int idx);
    regWrite   = v.wr[0];
    writeAdr   = v.wa[4:0];
    writeData  = v.wd;
    issueValid = v.iv[0];
    issueAdr   = v.ia[4:0];
    flush      = v.fl[0];
    rdAdr      = {v.ra1[4:0], v.ra0[4:0]};
    #2;
    check($sformatf("v%0d.data0", idx), rdData[31:0], v.ed0);
    check($sformatf("v%0d.data1", idx), rdData[63:32], v.ed1);
    check($sformatf("v%0d.busy0", idx), 32'(rdBusy[0]), v.eb0);
    check($sformatf("v%0d.busy1", idx), 32'(rdBusy[1]), v.eb1);
    check($sformatf("v%0d.stall", idx), 32'(issueStall), v.es);
    check($sformatf("v%0d.count", idx), 32'(busyCount), v.ec);
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rstN = 1'b0;
    rdAdr = '0;
    sRdAdr = '0;
    idleInputs();

    //           wr wa wd            iv ia fl ra0 ra1 ed0           ed1           eb0 eb1 es ec
    vecs[0]  = '{0, 0, 0,            0, 0, 0, 0,  8,  0,            0,            0,  0,  0, 0};
    vecs[1]  = '{1, 8, 32'hDEADBEEF, 0, 0, 0, 1,  2,  0,            0,            0,  0,  0, 0};
    vecs[2]  = '{1, 0, 5,            0, 0, 0, 8,  8,  32'hDEADBEEF, 32'hDEADBEEF, 0,  0,  0, 0};
    vecs[3]  = '{0, 0, 0,            0, 0, 0, 0,  8,  0,            32'hDEADBEEF, 0,  0,  0, 0};
    vecs[4]  = '{0, 0, 0,            1, 5, 0, 5,  0,  0,            0,            0,  0,  0, 0};
    vecs[5]  = '{0, 0, 0,            1, 5, 0, 5,  8,  0,            32'hDEADBEEF, 1,  0,  1, 1};
    vecs[6]  = '{1, 5, 32'h55,       1, 5, 0, 8,  9,  32'hDEADBEEF, 0,            0,  0,  0, 1};
    vecs[7]  = '{0, 0, 0,            0, 0, 0, 5,  8,  32'h55,       32'hDEADBEEF, 1,  0,  0, 1};
    vecs[8]  = '{0, 0, 0,            1, 1, 0, 1,  5,  0,            32'h55,       0,  1,  0, 1};
    vecs[9]  = '{0, 0, 0,            1, 2, 0, 1,  2,  0,            0,            1,  0,  0, 2};
    vecs[10] = '{0, 0, 0,            1, 3, 0, 2,  3,  0,            0,            1,  0,  0, 3};
    vecs[11] = '{1, 9, 32'h99,       1, 4, 1, 3,  4,  0,            0,            1,  0,  0, 4};
    vecs[12] = '{0, 0, 0,            0, 0, 0, 4,  9,  0,            32'h99,       0,  0,  0, 0};
    vecs[13] = '{0, 0, 0,            1, 0, 0, 0,  0,  0,            0,            0,  0,  0, 0};
    vecs[14] = '{0, 0, 0,            0, 0, 0, 9,  5,  32'h99,       32'h55,       0,  0,  0, 0};

    // Reset state while rstN is held low
    rdAdr = {5'd31, 5'd8};
    #3;
    check("reset.data", rdData[31:0], 32'h0);
    check("reset.busy", 32'(rdBusy), 32'h0);
    check("reset.count", 32'(busyCount), 32'h0);
    #4 rstN = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      applyVec(vecs[i], i);
    end
    idleInputs();

    // Write to a pending register while reading it in the same cycle
    issueValid = 1'b1; issueAdr = 5'd3;
    tick();
    idleInputs();
    rdAdr = {5'd0, 5'd3};
    tick();
    #2;
    check("byp.preBusy", 32'(rdBusy[0]), 32'h1);
    check("byp.preCount", 32'(busyCount), 32'h1);
    tick();
    regWrite = 1'b1; writeAdr = 5'd3; writeData = 32'h1234;
    #2;
`ifdef REGFILE_BYPASS_EN
    check("byp.sameData", rdData[31:0], 32'h1234);
    check("byp.sameBusy", 32'(rdBusy[0]), 32'h0);
`else
    check("byp.sameData", rdData[31:0], 32'h0);
    check("byp.sameBusy", 32'(rdBusy[0]), 32'h1);
`endif
    tick();
    idleInputs();
    #2;
    check("byp.nextData", rdData[31:0], 32'h1234);
    check("byp.nextBusy", 32'(rdBusy[0]), 32'h0);
    check("byp.nextCount", 32'(busyCount), 32'h0);
    tick();

    // Asynchronous reset mid-cycle with pending state
    issueValid = 1'b1; issueAdr = 5'd6;
    tick();
    idleInputs();
    #1;
    check("prerst.count", 32'(busyCount), 32'h1);
    rstN = 1'b0;
    #1;
    check("rst.count", 32'(busyCount), 32'h0);
    for (int a = 0; a < 32; a++) begin
      rdAdr = {5'(31 - a), 5'(a)};
      #0.1;
      check($sformatf("rst.data.r%0d", a), rdData[31:0] | rdData[63:32], 32'h0);
      check($sformatf("rst.busy.r%0d", a), 32'(rdBusy), 32'h0);
    end
    issueValid = 1'b1; issueAdr = 5'd6;
    #0.1;
    check("rst.stall", 32'(issueStall), 32'h0);
    idleInputs();
    rstN = 1'b1;
    tick();
    regWrite = 1'b1; writeAdr = 5'd8; writeData = 32'h11;
    issueValid = 1'b1; issueAdr = 5'd2;
    tick();
    idleInputs();
    rdAdr = {5'd2, 5'd8};
    #2;
    check("postrst.r8", rdData[31:0], 32'h11);
    check("postrst.r2busy", 32'(rdBusy[1]), 32'h1);
    check("postrst.count", 32'(busyCount), 32'h1);
    tick();

    // Small configuration: fill r1..r7 (write and issue together; set wins)
    for (int i = 1; i < 8; i++) begin
      sRegWrite = 1'b1; sWriteAdr = 3'(i); sWriteData = 16'hA000 + 16'(i);
      sIssueValid = 1'b1; sIssueAdr = 3'(i);
      tick();
    end
    idleInputs();
    sRdAdr = {3'd7, 3'd5, 3'd3, 3'd1};
    #2;
    check("sm.count", 32'(sBusyCount), 32'h7);
    check("sm.p0", 32'(sRdData[15:0]),  32'hA001);
    check("sm.p1", 32'(sRdData[31:16]), 32'hA003);
    check("sm.p2", 32'(sRdData[47:32]), 32'hA005);
    check("sm.p3", 32'(sRdData[63:48]), 32'hA007);
    check("sm.busyA", 32'(sRdBusy), 32'hF);
    sRdAdr = {3'd0, 3'd6, 3'd4, 3'd2};
    #1;
    check("sm.q0", 32'(sRdData[15:0]),  32'hA002);
    check("sm.q1", 32'(sRdData[31:16]), 32'hA004);
    check("sm.q2", 32'(sRdData[47:32]), 32'hA006);
    check("sm.q3", 32'(sRdData[63:48]), 32'h0);
    check("sm.busyB", 32'(sRdBusy), 32'h7);
    sIssueValid = 1'b1; sIssueAdr = 3'd1;
    #1;
    check("sm.stall", 32'(sIssueStall), 32'h1);
    tick();
    idleInputs();
    #1;
    check("sm.countHold", 32'(sBusyCount), 32'h7);
    sFlush = 1'b1;
    tick();
    idleInputs();
    #1;
    check("sm.flushCount", 32'(sBusyCount), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port register file with an integrated pending-write scoreboard, used by the pipelined MIPS datapath in ID stage. It provides READ_PORTS combinational read ports, one synchronous write port, write-to-read bypass and per-register busy tracking. The decode stage uses the busy tracking to detect RAW and WAW hazards without a separate hazard unit. Register 0 is hard-wired to zero.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers (power of two, ≥2)
- ADDR_W, 5, address width, equals log2(DEPTH)
- READ_PORTS, 2, number of independent read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rstN  in  1  asynchronous, active-low reset
- rdAdr  in  READ_PORTS*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rdData  out  READ_PORTS*WIDTH  read data; port i occupies bits [i*WIDTH +: WIDTH]
- rdBusy  out  READ_PORTS  port i's register has a pending write not yet available
- regWrite  in  1  write enable
- writeAdr  in  ADDR_W  write address
- writeData  in  WIDTH  write data
- issueValid  in  1  decode requests to mark issueAdr as pending
- issueAdr  in  ADDR_W  destination register of the issuing instruction
- issueStall  out  1  issue refused this cycle (WAW hazard)
- flush  in  1  synchronous clear of all busy bits (branch/exception squash)
- busyCount  out  ADDR_W+1  number of registers currently busy

## Operation
- Storage: DEPTH×WIDTH array plus a DEPTH-bit busy vector; entry 0 is never written and never busy.
- Read: rdData[i] = 0 if rdAdr[i]==0. Otherwise it is the array contents, or writeData when bypass is enabled and regWrite && writeAdr==rdAdr[i].
- rdBusy[i] = busy[rdAdr[i]]. With bypass enabled, rdBusy[i] is forced to 0 when a same-cycle write to that address is forwarded. rdBusy[i] is always 0 for address 0.
- Write: on rising edge, if regWrite && writeAdr!=0, the array entry is updated and busy[writeAdr] is cleared. Writes to address 0 are dropped.
- Issue: issueStall = issueValid && issueAdr!=0 && busy[issueAdr] && !(regWrite && writeAdr==issueAdr).
  - Accepted issue (issueValid && !issueStall && issueAdr!=0 && !flush) sets busy[issueAdr] at the edge.
  - Issue to address 0 is always accepted and has no effect.
- Simultaneous write and accepted issue to the same address: the set wins, so busy stays 1 (new producer). The data write still lands.
- flush: all busy bits are cleared at the edge. A same-cycle issue is discarded. A same-cycle write still updates the array.
- busyCount: registered population count of the busy vector, updated in the same edge as the busy vector, so it is always consistent with it.

## Timing
- Read latency 0 cycles (combinational from rdAdr/regWrite/writeAdr/writeData).
- Write, issue and flush take effect at the next rising edge. A write becomes visible from the array one cycle after the edge, or in the same cycle via bypass.
- issueStall is combinational and valid in the same cycle as issueValid.
- Reset (rstN low, asynchronous): all array entries are 0, busy vector is 0, busyCount is 0. rdData=0, rdBusy=0 and issueStall=0 whenever the inputs reference cleared state.
- Reset deasserted mid-operation: the first edge after release behaves as a normal cycle. No pending state survives reset.
- busyCount range is 0..DEPTH-1 (register 0 is excluded). There is no wrap-around.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write data is forwarded to matching read ports, and rdBusy is suppressed for the forwarded address.
- Without REGFILE_BYPASS_EN: reads return the stored value only. rdBusy for the written register stays 1 in the write cycle and drops the cycle after. Decode must stall one extra cycle.

## Test plan
- Reset: pull rstN low mid-cycle, then read all addresses -> rdData=0, rdBusy=0, busyCount=0 immediately (asynchronous).
- Write then read: write 0xDEADBEEF to r8, next cycle read r8 on both ports -> 0xDEADBEEF. Write 0x5 to r0 -> r0 still reads 0.
- Bypass: issue r3, wait 2 cycles, then regWrite r3=0x1234 while reading r3 -> with macro: rdData=0x1234, rdBusy=0 in the same cycle; without macro: old value, rdBusy=1, then 0x1234 and rdBusy=0 next cycle.
- WAW: issue r5 (busyCount=1), issue r5 again -> issueStall=1, busyCount stays 1. Then issue r5 while regWrite r5 -> accepted, busy[r5] stays 1, busyCount=1.
- Flush: issue r1, r2, r3 (busyCount=3), then assert flush with issueValid r4 -> busyCount=0, r4 not busy.
- Parameter sweep: WIDTH=16, DEPTH=8, READ_PORTS=4 -> 4 ports read distinct registers correctly, busyCount saturates at 7 with r1..r7 issued.
